// File: rtl/stratix_lvds_rx_aligner_if.sv
// ---------------------------------------------------------------------------
// stratix_lvds_rx_aligner_if
// Bundles the data-side signals of the LVDS receive word aligner.
//   master : the producer (deserializer/test driver). It drives rx_data,
//            rx_data_valid and align_enable, and observes the aligner outputs.
//   slave  : the aligner itself. It consumes the deserialized words and drives
//            rx_aligned, rx_aligned_valid, rx_locked, rx_align_fail and
//            rx_offset.
// Channel c occupies bits [c*F +: F] of rx_data and rx_aligned. It occupies
// bits [c*4 +: 4] of rx_offset.
// ---------------------------------------------------------------------------
interface stratix_lvds_rx_aligner_if #(
    parameter int number_of_channels     = 1,
    parameter int deserialization_factor = 4
);
    localparam int REGISTER_WIDTH = deserialization_factor * number_of_channels;

    logic [REGISTER_WIDTH-1:0]       rx_data;
    logic                            rx_data_valid;
    logic                            align_enable;
    logic [REGISTER_WIDTH-1:0]       rx_aligned;
    logic                            rx_aligned_valid;
    logic [number_of_channels-1:0]   rx_locked;
    logic [number_of_channels-1:0]   rx_align_fail;
    logic [4*number_of_channels-1:0] rx_offset;

    modport master (
        output rx_data,
        output rx_data_valid,
        output align_enable,
        input  rx_aligned,
        input  rx_aligned_valid,
        input  rx_locked,
        input  rx_align_fail,
        input  rx_offset
    );

    modport slave (
        input  rx_data,
        input  rx_data_valid,
        input  align_enable,
        output rx_aligned,
        output rx_aligned_valid,
        output rx_locked,
        output rx_align_fail,
        output rx_offset
    );
endinterface

// File: rtl/stratix_lvds_rx_aligner.sv
// ---------------------------------------------------------------------------
// stratix_lvds_rx_aligner
// Word aligner that sits behind the Stratix LVDS deserializer. Each channel
// slides a window across its last two words. It stops when the training word
// has been seen LOCK_COUNT times in a row. While locked it forwards the words
// bit-aligned.
//
// Ports
//   rx_coreclk : core clock. It is the only clock in the block.
//   aclr       : active-high reset. Assertion takes effect at once.
//                Release is synchronised to rx_coreclk.
//   bus        : slave side of stratix_lvds_rx_aligner_if
//                rx_data / rx_data_valid  deserialized words, with bit F-1
//                                         being the oldest bit
//                align_enable             training-mode request
//                rx_aligned / _valid      aligned words, one clock later
//                rx_locked                per-channel lock flag
//                rx_align_fail            per-channel sticky sweep-exhaustion
//                rx_offset                per-channel bit offset k (4 bits)
// ---------------------------------------------------------------------------
module stratix_lvds_rx_aligner #(
    parameter int                                number_of_channels     = 1,
    parameter int                                deserialization_factor = 4,
    parameter logic [deserialization_factor-1:0] TRAINING_PATTERN       = 4'b0011,
    parameter int                                LOCK_COUNT             = 4,
    parameter int                                MAX_SWEEPS             = 8
) (
    input  logic                     rx_coreclk,
    input  logic                     aclr,
    stratix_lvds_rx_aligner_if.slave bus
);
    localparam int         F              = deserialization_factor;
    localparam int         NC             = number_of_channels;
    localparam int         REGISTER_WIDTH = F * NC;
    localparam logic [3:0] K_LAST         = 4'(F - 1);
    localparam logic [7:0] LOCK_LIMIT     = 8'(LOCK_COUNT);
    localparam logic [7:0] SWEEP_LIMIT    = 8'(MAX_SWEEPS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_VERIFY = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    // Reset bridge. aclr sets both stages at once, so every register below is
    // cleared immediately. Deassertion ripples through two clock edges, so
    // no register leaves reset close to a clock edge.
    logic [1:0] rst_sync_reg;
    logic       rst;

    always_ff @(posedge rx_coreclk or posedge aclr) begin
        if (aclr) begin
            rst_sync_reg <= 2'b11;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b0};
        end
    end

    assign rst = rst_sync_reg[1];

    // Signals shared by all channels.
    logic align_enable_reg;
    logic aligned_valid_reg;
    logic retrain;

    always_ff @(posedge rx_coreclk or posedge rst) begin
        if (rst) begin
            align_enable_reg  <= 1'b0;
            aligned_valid_reg <= 1'b0;
        end else begin
            align_enable_reg  <= bus.align_enable;
            aligned_valid_reg <= bus.rx_data_valid;
        end
    end

    // Only a fresh rising edge of align_enable restarts training on a channel
    // that is locked. Holding align_enable high does not restart it.
    assign retrain = bus.align_enable & ~align_enable_reg;

    wire [REGISTER_WIDTH-1:0] aligned_w;
    wire [NC-1:0]             locked_w;
    wire [NC-1:0]             fail_w;
    wire [4*NC-1:0]           offset_w;

    generate
        for (genvar gi = 0; gi < NC; gi++) begin : g_chan
            logic [F-1:0]   cur;
            logic [F-1:0]   prev_reg;
            logic [F-1:0]   win;
            logic [F-1:0]   aligned_reg;
            logic [2*F-1:0] pair_shifted;
            state_t         state_reg;
            state_t         state_next;
            logic [3:0]     k_reg;
            logic [3:0]     k_next;
            logic [3:0]     k_adv;
            logic [7:0]     match_reg;
            logic [7:0]     match_next;
            logic [7:0]     sweep_reg;
            logic [7:0]     sweep_next;
            logic [7:0]     sweep_adv;
            logic           fail_reg;
            logic           fail_next;
            logic           fail_adv;
            logic           wrap;
            logic           hit;
            logic           locked;

            assign cur = bus.rx_data[gi*F +: F];

            // window(k) = {prev, cur}[F-1+k : k]. Shifting right by k brings
            // older bits into the low F positions.
            assign pair_shifted = {prev_reg, cur} >> k_reg;
            assign win          = pair_shifted[F-1:0];
            assign hit          = (win == TRAINING_PATTERN);

            // Values that apply when the channel moves on to the next offset.
            // sweep_cnt stops at the limit. fail stays set until retrain.
            assign wrap      = (k_reg == K_LAST);
            assign k_adv     = wrap ? 4'd0 : k_reg + 4'd1;
            assign sweep_adv = (wrap && (sweep_reg != SWEEP_LIMIT)) ? sweep_reg + 8'd1 : sweep_reg;
            assign fail_adv  = fail_reg | (wrap && (sweep_adv == SWEEP_LIMIT));

            // Data path: prev and the aligned word advance only on valid
            // words. The window uses the offset from before this cycle.
            always_ff @(posedge rx_coreclk or posedge rst) begin
                if (rst) begin
                    prev_reg    <= '0;
                    aligned_reg <= '0;
                end else if (bus.rx_data_valid) begin
                    prev_reg    <= cur;
                    aligned_reg <= win;
                end
            end

            // State register.
            always_ff @(posedge rx_coreclk or posedge rst) begin
                if (rst) begin
                    state_reg <= ST_IDLE;
                    k_reg     <= 4'd0;
                    match_reg <= 8'd0;
                    sweep_reg <= 8'd0;
                    fail_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    k_reg     <= k_next;
                    match_reg <= match_next;
                    sweep_reg <= sweep_next;
                    fail_reg  <= fail_next;
                end
            end

            // Next-state logic. Compare and advance steps happen only on valid
            // words. Changes driven by align_enable happen on any cycle.
            always_comb begin
                state_next = state_reg;
                k_next     = k_reg;
                match_next = match_reg;
                sweep_next = sweep_reg;
                fail_next  = fail_reg;
                unique case (state_reg)
                    ST_IDLE: begin
                        // A word that arrives together with the request is
                        // not compared. k keeps its last value.
                        if (bus.align_enable) begin
                            state_next = ST_SEARCH;
                            match_next = 8'd0;
                            sweep_next = 8'd0;
                            fail_next  = 1'b0;
                        end
                    end
                    ST_SEARCH: begin
                        if (!bus.align_enable) begin
                            state_next = ST_IDLE;
                        end else if (bus.rx_data_valid) begin
                            if (hit) begin
                                match_next = 8'd1;
                                state_next = (LOCK_LIMIT == 8'd1) ? ST_LOCKED : ST_VERIFY;
                            end else begin
                                k_next     = k_adv;
                                sweep_next = sweep_adv;
                                fail_next  = fail_adv;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (!bus.align_enable) begin
                            state_next = ST_IDLE;
                        end else if (bus.rx_data_valid) begin
                            if (hit) begin
                                match_next = match_reg + 8'd1;
                                if ((match_reg + 8'd1) == LOCK_LIMIT) begin
                                    state_next = ST_LOCKED;
                                end
                            end else begin
                                state_next = ST_SEARCH;
                                match_next = 8'd0;
                                k_next     = k_adv;
                                sweep_next = sweep_adv;
                                fail_next  = fail_adv;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        // The offset is frozen and the payload is not checked.
                        // Only a rising edge of align_enable leaves this state.
                        if (retrain) begin
                            state_next = ST_SEARCH;
                            match_next = 8'd0;
                            sweep_next = 8'd0;
                            fail_next  = 1'b0;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end

            // Output decode.
            always_comb begin
                locked = (state_reg == ST_LOCKED);
            end

            assign aligned_w[gi*F +: F] = aligned_reg;
            assign locked_w[gi]         = locked;
            assign fail_w[gi]           = fail_reg;
            assign offset_w[gi*4 +: 4]  = k_reg;
        end
    endgenerate

    assign bus.rx_aligned       = aligned_w;
    assign bus.rx_aligned_valid = aligned_valid_reg;
    assign bus.rx_locked        = locked_w;
    assign bus.rx_align_fail    = fail_w;
    assign bus.rx_offset        = offset_w;

endmodule

// File: tb/tb_stratix_lvds_rx_aligner.sv
// ---------------------------------------------------------------------------
// tb_stratix_lvds_rx_aligner
// Two-channel, F=4 bench for the LVDS word aligner. The training word is
// 0011, LOCK_COUNT is 4 and MAX_SWEEPS is 2. A small channel model pushes the
// expected aligned word to a queue for every valid input. The queue is popped
// when the DUT flags rx_aligned_valid. Lock, offset and fail outputs are
// compared against the model after every clock. Fixed values that follow
// from the training sequences are also checked at key points.
// ---------------------------------------------------------------------------
module tb_stratix_lvds_rx_aligner;
    localparam int         NC         = 2;
    localparam int         F          = 4;
    localparam int         LOCK_COUNT = 4;
    localparam int         MAX_SWEEPS = 2;
    localparam logic [3:0] PATTERN    = 4'b0011;

    localparam int S_IDLE   = 0;
    localparam int S_SEARCH = 1;
    localparam int S_VERIFY = 2;
    localparam int S_LOCKED = 3;

    logic clk  = 1'b0;
    logic aclr = 1'b0;

    always #5 clk = ~clk;

    stratix_lvds_rx_aligner_if #(
        .number_of_channels    (NC),
        .deserialization_factor(F)
    ) bus_if ();

    stratix_lvds_rx_aligner #(
        .number_of_channels    (NC),
        .deserialization_factor(F),
        .TRAINING_PATTERN      (PATTERN),
        .LOCK_COUNT            (LOCK_COUNT),
        .MAX_SWEEPS            (MAX_SWEEPS)
    ) dut (
        .rx_coreclk(clk),
        .aclr      (aclr),
        .bus       (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [7:0] exp_q[$];

    // Channel model state.
    int         m_state[NC];
    int         m_k[NC];
    int         m_match[NC];
    int         m_sweep[NC];
    logic       m_fail[NC];
    logic [3:0] m_prev[NC];
    logic       m_ae_reg;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_state[c] = S_IDLE;
            m_k[c]     = 0;
            m_match[c] = 0;
            m_sweep[c] = 0;
            m_fail[c]  = 1'b0;
            m_prev[c]  = 4'd0;
        end
        m_ae_reg = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_advance(input int c);
        if (m_k[c] == F - 1) begin
            m_k[c] = 0;
            if (m_sweep[c] < MAX_SWEEPS) m_sweep[c]++;
            if (m_sweep[c] == MAX_SWEEPS) m_fail[c] = 1'b1;
        end else begin
            m_k[c]++;
        end
    endtask

    task automatic model_step(input logic [7:0] data, input logic valid, input logic ae);
        logic [7:0] exp_word;
        logic [3:0] cur;
        logic [7:0] pair;
        logic [3:0] win;
        logic       rise;
        exp_word = 8'h00;
        rise     = ae && !m_ae_reg;
        for (int c = 0; c < NC; c++) begin
            cur  = data[c*F +: F];
            pair = {m_prev[c], cur} >> m_k[c];
            win  = pair[3:0];
            case (m_state[c])
                S_IDLE: begin
                    if (ae) begin
                        m_state[c] = S_SEARCH;
                        m_match[c] = 0;
                        m_sweep[c] = 0;
                        m_fail[c]  = 1'b0;
                    end
                end
                S_SEARCH: begin
                    if (!ae) begin
                        m_state[c] = S_IDLE;
                    end else if (valid) begin
                        if (win == PATTERN) begin
                            m_match[c] = 1;
                            m_state[c] = (LOCK_COUNT == 1) ? S_LOCKED : S_VERIFY;
                        end else begin
                            model_advance(c);
                        end
                    end
                end
                S_VERIFY: begin
                    if (!ae) begin
                        m_state[c] = S_IDLE;
                    end else if (valid) begin
                        if (win == PATTERN) begin
                            m_match[c]++;
                            if (m_match[c] == LOCK_COUNT) m_state[c] = S_LOCKED;
                        end else begin
                            m_state[c] = S_SEARCH;
                            m_match[c] = 0;
                            model_advance(c);
                        end
                    end
                end
                default: begin
                    if (rise) begin
                        m_state[c] = S_SEARCH;
                        m_match[c] = 0;
                        m_sweep[c] = 0;
                        m_fail[c]  = 1'b0;
                    end
                end
            endcase
            if (valid) begin
                exp_word[c*F +: F] = win;
                m_prev[c]          = cur;
            end
        end
        m_ae_reg = ae;
        if (valid) exp_q.push_back(exp_word);
    endtask

    // One clock: drive inputs, step the model at the edge, then check the
    // DUT 1 ns after the edge.
    task automatic cycle(input logic [7:0] data, input logic valid, input logic ae);
        logic [7:0] exp_word;
        logic [1:0] exp_locked;
        logic [1:0] exp_fail;
        logic [7:0] exp_offset;
        bus_if.rx_data       = data;
        bus_if.rx_data_valid = valid;
        bus_if.align_enable  = ae;
        @(posedge clk);
        model_step(data, valid, ae);
        #1;
        txn++;
        check_val("aligned_valid", 32'(bus_if.rx_aligned_valid), 32'(valid));
        if (bus_if.rx_aligned_valid) begin
            if (exp_q.size() == 0) begin
                check_val("sb_depth", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_word = exp_q.pop_front();
                check_val("aligned", 32'(bus_if.rx_aligned), 32'(exp_word));
            end
        end
        for (int c = 0; c < NC; c++) begin
            exp_locked[c]        = (m_state[c] == S_LOCKED);
            exp_fail[c]          = m_fail[c];
            exp_offset[c*4 +: 4] = 4'(m_k[c]);
        end
        check_val("locked", 32'(bus_if.rx_locked), 32'(exp_locked));
        check_val("offset", 32'(bus_if.rx_offset), 32'(exp_offset));
        check_val("sticky_flag", 32'(bus_if.rx_align_fail), 32'(exp_fail));
        $display("txn %0d in=%h v=%b ae=%b out=%h ov=%b lock=%b off=%h sticky=%b",
                 txn, data, valid, ae, bus_if.rx_aligned, bus_if.rx_aligned_valid,
                 bus_if.rx_locked, bus_if.rx_offset, bus_if.rx_align_fail);
    endtask

    // Asserts aclr between clock edges and checks that the outputs clear at
    // once. Then releases aclr and idles until the synchronised release is done.
    task automatic apply_reset();
        bus_if.rx_data       = 8'h00;
        bus_if.rx_data_valid = 1'b0;
        bus_if.align_enable  = 1'b0;
        aclr = 1'b1;
        #2;
        check_val("rst_aligned", 32'(bus_if.rx_aligned), 32'd0);
        check_val("rst_aligned_valid", 32'(bus_if.rx_aligned_valid), 32'd0);
        check_val("rst_locked", 32'(bus_if.rx_locked), 32'd0);
        check_val("rst_sticky", 32'(bus_if.rx_align_fail), 32'd0);
        check_val("rst_offset", 32'(bus_if.rx_offset), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        aclr = 1'b0;
        repeat (3) cycle(8'h00, 1'b0, 1'b0);
    endtask

    task automatic feed(input logic [7:0] word, input int n);
        for (int i = 0; i < n; i++) cycle(word, 1'b1, 1'b1);
    endtask

    initial begin
        bus_if.rx_data       = 8'h00;
        bus_if.rx_data_valid = 1'b0;
        bus_if.align_enable  = 1'b0;
        model_reset();
        #1;

        // Phase 1 on both lanes (0110 each).
        apply_reset();
        cycle(8'h00, 1'b0, 1'b1);
        for (int w = 1; w <= 8; w++) begin
            cycle(8'h66, 1'b1, 1'b1);
            if (w == 1) check_val("t1_offset_w1", 32'(bus_if.rx_offset), 32'h11);
            if (w == 1) check_val("t1_aligned_w1", 32'(bus_if.rx_aligned), 32'h66);
            if (w >= 2) check_val("t1_aligned", 32'(bus_if.rx_aligned), 32'h33);
            check_val("t1_lock_time", 32'(bus_if.rx_locked), (w >= 5) ? 32'h3 : 32'h0);
        end

        // Zero offset: the data passes through one clock later.
        apply_reset();
        cycle(8'h00, 1'b0, 1'b1);
        for (int w = 1; w <= 6; w++) begin
            cycle(8'h33, 1'b1, 1'b1);
            check_val("t2_passthru", 32'(bus_if.rx_aligned), 32'h33);
            check_val("t2_offset", 32'(bus_if.rx_offset), 32'h00);
            check_val("t2_lock_time", 32'(bus_if.rx_locked), (w >= 4) ? 32'h3 : 32'h0);
        end

        // Sweep exhaustion, lock with the sticky flag set, then retrain.
        apply_reset();
        cycle(8'h00, 1'b0, 1'b1);
        for (int w = 1; w <= 8; w++) begin
            logic [7:0] e_off;
            e_off = {2{4'(w % 4)}};
            cycle(8'h00, 1'b1, 1'b1);
            check_val("t3_offset_cycle", 32'(bus_if.rx_offset), 32'(e_off));
            check_val("t3_sticky_rise", 32'(bus_if.rx_align_fail), (w == 8) ? 32'h3 : 32'h0);
        end
        feed(8'h66, 6);
        check_val("t3_locked_k1", 32'(bus_if.rx_locked), 32'h3);
        check_val("t3_offset_k1", 32'(bus_if.rx_offset), 32'h11);
        check_val("t3_sticky_kept", 32'(bus_if.rx_align_fail), 32'h3);
        cycle(8'h66, 1'b1, 1'b0);
        check_val("t3_lock_ignores_low", 32'(bus_if.rx_locked), 32'h3);
        cycle(8'h66, 1'b1, 1'b1);
        check_val("t3_sticky_clear", 32'(bus_if.rx_align_fail), 32'h0);
        check_val("t3_retrain_unlock", 32'(bus_if.rx_locked), 32'h0);
        feed(8'h66, 4);
        check_val("t3_relock", 32'(bus_if.rx_locked), 32'h3);

        // A mismatch during verify sends the channel back to search.
        apply_reset();
        cycle(8'h00, 1'b0, 1'b1);
        for (int w = 1; w <= 13; w++) begin
            cycle((w == 4) ? 8'hFF : 8'h66, 1'b1, 1'b1);
            if (w == 4) check_val("t4_offset_2", 32'(bus_if.rx_offset), 32'h22);
            if (w == 6) check_val("t4_offset_wrap", 32'(bus_if.rx_offset), 32'h00);
            check_val("t4_no_glitch", 32'(bus_if.rx_locked), (w >= 11) ? 32'h3 : 32'h0);
        end
        check_val("t4_final_k", 32'(bus_if.rx_offset), 32'h11);

        // Sparse valid: words arrive only on even cycles.
        apply_reset();
        cycle(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            logic v;
            v = (i % 2 == 0);
            cycle(v ? 8'h66 : 8'hFF, v, 1'b1);
            check_val("t5_lock_time", 32'(bus_if.rx_locked), (i >= 8) ? 32'h3 : 32'h0);
        end

        // Independent channels: lane 0 at phase 1, lane 1 at phase 3.
        apply_reset();
        cycle(8'h00, 1'b0, 1'b1);
        for (int w = 1; w <= 8; w++) begin
            cycle(8'h96, 1'b1, 1'b1);
            if (w == 5) check_val("t6_lane0_lock", 32'(bus_if.rx_locked), 32'h1);
            if (w == 7) check_val("t6_both_lock", 32'(bus_if.rx_locked), 32'h3);
        end
        check_val("t6_offsets", 32'(bus_if.rx_offset), 32'h31);
        apply_reset();
        cycle(8'h00, 1'b0, 1'b1);
        feed(8'h96, 7);
        check_val("t6_relock", 32'(bus_if.rx_locked), 32'h3);
        check_val("t6_reoffsets", 32'(bus_if.rx_offset), 32'h31);

        check_val("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
